dmem_arbiter: RTL

Two-port arbiter and access sequencer for the 32-word data memory. Shares the memory between the CPU load/store port (port 0) and an auxiliary port (port 1; debug or preload). Grants one request at a time and drives the memory's level-sensitive `readMem`/`writeMem` strobes as clean single-cycle pulses separated by idle cycles. Returns read data with a one-cycle `done` pulse per transaction.

---
 rtl/dmem_arb_pkg.sv | 28 ++
 rtl/dmem_rr_pick.sv | 40 ++++
 rtl/dmem_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the two-port data-memory arbiter:
//   - arb_state_t    : sequencer state encoding (IDLE / ACCESS / RESP)
//   - PORT_CPU/AUX   : port index constants
//   - DEFAULT_IDX_W  : default number of word-index bits the memory decodes
//   - port_onehot()  : maps a 1-bit port index to a 2-bit one-hot vector
// Configuration macro: DMEM_ARB_FIXED_PRIO_EN (consumed by dmem_rr_pick and
// dmem_arbiter, not by this package).
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam int PORT_CPU      = 0;
    localparam int PORT_AUX      = 1;
    localparam int NUM_PORTS     = 2;
    localparam int DEFAULT_IDX_W = 5;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// ----------------------------------------------------------------------------
// dmem_rr_pick
// Combinational two-way winner select.
// Ports:
//   req   in  2  per-port request
//   last  in  1  most recent winner (round-robin build only)
//   valid out 1  at least one port is requesting
//   grant out 1  index of the winning port (meaningful only with valid)
// Configuration macro: DMEM_ARB_FIXED_PRIO_EN
//   defined   -> port 0 wins every tie, no 'last' input
//   undefined -> on a tie the port that did not win last time wins
// ----------------------------------------------------------------------------
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
`ifndef DMEM_ARB_FIXED_PRIO_EN
    input  logic                 last,
`endif
    output logic                 valid,
    output logic                 grant
);

    always_comb begin
        valid = |req;
        grant = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        // Port 1 only wins when port 0 is silent.
        grant = req[PORT_AUX] & ~req[PORT_CPU];
`else
        if (req == 2'b11) begin
            grant = ~last;
        end else begin
            // Lone requester (or nobody): req[1] alone selects port 1.
            grant = req[PORT_AUX];
        end
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares the data memory between the CPU port (0) and an auxiliary port (1).
// One transaction at a time: IDLE (accept + latch) -> ACCESS (one strobe) ->
// RESP (done pulse) -> IDLE, so strobes are single-cycle and never adjacent.
// Ports (port i uses bits [i*W +: W] of each packed bus):
//   clk, rst_n             clock, asynchronous active-low reset
//   req, we                per-port request / write enable
//   addr, wdata            per-port word address / store data
//   done, err, rdata       per-port completion pulse, error flag, load data
//   memAddress             registered memory address
//   memWriteData           registered memory store data
//   memWriteMem/ReadMem    single-cycle memory strobes
//   memReadData            memory read data (sampled at the end of ACCESS)
// Configuration macro: DMEM_ARB_FIXED_PRIO_EN (fixed priority, no 'last').
// ----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int IDX_W  = DEFAULT_IDX_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
    output logic [NUM_PORTS-1:0]          done,
    output logic [NUM_PORTS-1:0]          err,
    output logic [NUM_PORTS*DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]             memAddress,
    output logic [DATA_W-1:0]             memWriteData,
    output logic                          memWriteMem,
    output logic                          memReadMem,
    input  logic [DATA_W-1:0]             memReadData
);

    arb_state_t state_reg, state_next;

    logic              accept;      // IDLE with a winner: latch request
    logic              finish;      // last cycle of ACCESS: respond next

    logic              owner_reg;
    logic              we_reg;
    logic              oor_reg;     // latched address was out of range
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              mem_rd_reg;
    logic              mem_wr_reg;
    logic [NUM_PORTS-1:0] done_reg;
    logic [NUM_PORTS-1:0] err_reg;

    logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
    logic [DATA_W-1:0] wdata_arr [NUM_PORTS];
    logic [DATA_W-1:0] rdata_reg [NUM_PORTS];

    logic              pick_valid;
    logic              pick_grant;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_oor;
    logic              sel_we;

    // ------------------------------------------------------------------
    // Per-port bus unpacking and load-data registers
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign addr_arr[gi]                  = addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi]                 = wdata[gi*DATA_W +: DATA_W];
            assign rdata[gi*DATA_W +: DATA_W]    = rdata_reg[gi];

            // Loads capture memory data at the edge that ends ACCESS;
            // an out-of-range access clears the port's data; stores keep it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_reg[gi] <= '0;
                end else if (finish && (owner_reg == 1'(gi))) begin
                    if (oor_reg) begin
                        rdata_reg[gi] <= '0;
                    end else if (!we_reg) begin
                        rdata_reg[gi] <= memReadData;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Winner select
    // ------------------------------------------------------------------
`ifdef DMEM_ARB_FIXED_PRIO_EN
    dmem_rr_pick u_pick (
        .req   (req),
        .valid (pick_valid),
        .grant (pick_grant)
    );
`else
    logic last_reg;

    dmem_rr_pick u_pick (
        .req   (req),
        .last  (last_reg),
        .valid (pick_valid),
        .grant (pick_grant)
    );

    // Reset to port 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
        end else if (accept) begin
            last_reg <= pick_grant;
        end
    end
`endif

    assign sel_addr = addr_arr[pick_grant];
    assign sel_we   = we[pick_grant];
    // Only the low IDX_W bits address a real word; anything above is an error.
    assign sel_oor  = |sel_addr[ADDR_W-1:IDX_W];

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    accept     = 1'b1;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                finish     = 1'b1;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, memory interface and response registers
    // ------------------------------------------------------------------
    // Strobes are registered on acceptance so they are high exactly during
    // ACCESS and come straight from flops (glitch-free for a level-sensitive
    // memory). Address/data are only reloaded on acceptance, so they hold
    // through ACCESS and RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg     <= 1'b0;
            we_reg        <= 1'b0;
            oor_reg       <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            done_reg      <= '0;
            err_reg       <= '0;
        end else begin
            mem_rd_reg <= 1'b0;
            mem_wr_reg <= 1'b0;
            if (accept) begin
                owner_reg     <= pick_grant;
                we_reg        <= sel_we;
                oor_reg       <= sel_oor;
                mem_addr_reg  <= sel_addr;
                mem_wdata_reg <= wdata_arr[pick_grant];
                mem_rd_reg    <= ~sel_we & ~sel_oor;
                mem_wr_reg    <=  sel_we & ~sel_oor;
            end
            done_reg <= finish            ? port_onehot(owner_reg) : '0;
            err_reg  <= (finish && oor_reg) ? port_onehot(owner_reg) : '0;
        end
    end

    assign memAddress   = mem_addr_reg;
    assign memWriteData = mem_wdata_reg;
    assign memReadMem   = mem_rd_reg;
    assign memWriteMem  = mem_wr_reg;
    assign done         = done_reg;
    assign err          = err_reg;

endmodule
